span_fill: RTL and testbench

SPAN_FILL -- requirements
Module: span_fill

---
 rtl/span_fill_if.sv | 39 +++
 rtl/span_fill.sv | 224 ++++++++++++++++++++++
 tb/tb_span_fill.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/span_fill_if.sv
// Span-fill bus: span command, z-buffer read port, pixel write port and status.
interface span_fill_if #(
    parameter int ADDR_W = 19
);
    // Pixel write handshake: pix_we is a valid that stays high, with pix_addr,
    // pix_z and pix_color frozen, until a cycle where pix_ready is also high;
    // that cycle transfers exactly one pixel and pix_we drops or moves on.
    logic              draw;
    logic [15:0]       start_x;
    logic [15:0]       end_x;
    logic [15:0]       zout1;
    logic [15:0]       zout2;
    logic [15:0]       y_coord;
    logic [7:0]        color;
    logic              zb_rd_en;
    logic [ADDR_W-1:0] zb_rd_addr;
    logic [15:0]       zb_rd_data;
    logic              pix_we;
    logic              pix_ready;
    logic [ADDR_W-1:0] pix_addr;
    logic [15:0]       pix_z;
    logic [7:0]        pix_color;
    logic              done;
    logic              busy;

    modport slave (
        input  draw, start_x, end_x, zout1, zout2, y_coord, color,
        input  zb_rd_data, pix_ready,
        output zb_rd_en, zb_rd_addr, pix_we, pix_addr, pix_z, pix_color,
        output done, busy
    );

    modport master (
        output draw, start_x, end_x, zout1, zout2, y_coord, color,
        output zb_rd_data, pix_ready,
        input  zb_rd_en, zb_rd_addr, pix_we, pix_addr, pix_z, pix_color,
        input  done, busy
    );
endinterface

// File: rtl/span_fill.sv
// Horizontal span rasteriser with depth interpolation and optional z-test.
// Macro SPAN_FILL_ZTEST_EN enables the z-buffer read/compare (READ/TEST states).
module span_fill #(
    parameter int H_RES  = 640,
    parameter int ADDR_W = 19
) (
    input  logic       clk,
    input  logic       reset,
    span_fill_if.slave io_span,
    output logic [2:0] o_dbg_state
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DIV   = 3'd1,
        READ  = 3'd2,
        TEST  = 3'd3,
        WRITE = 3'd4,
        STEP  = 3'd5,
        DONE  = 3'd6
    } state_t;

`ifdef SPAN_FILL_ZTEST_EN
    localparam state_t PIX_ENTRY = READ;
`else
    localparam state_t PIX_ENTRY = WRITE;
`endif
    localparam logic [16:0] HRES_L = 17'(H_RES);

    state_t            r_state;
    state_t            w_next;
    logic [15:0]       r_x;
    logic [15:0]       r_end_x;
    logic [15:0]       r_z;
    logic [15:0]       r_dx;
    logic [15:0]       r_quo;
    logic [15:0]       r_rem;
    logic [15:0]       r_err;
    logic              r_sign;
    logic [7:0]        r_color;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_cnt;

    // Span setup: order endpoints left to right, carrying their depths along.
    logic              w_swap;
    logic [15:0]       w_x_lo;
    logic [15:0]       w_x_hi;
    logic [15:0]       w_z_s;
    logic [15:0]       w_z_e;
    logic              w_neg;
    logic [15:0]       w_adz;
    logic [ADDR_W-1:0] w_base;

    assign w_swap = io_span.start_x > io_span.end_x;
    assign w_x_lo = w_swap ? io_span.end_x : io_span.start_x;
    assign w_x_hi = w_swap ? io_span.start_x : io_span.end_x;
    assign w_z_s  = w_swap ? io_span.zout2 : io_span.zout1;
    assign w_z_e  = w_swap ? io_span.zout1 : io_span.zout2;
    assign w_neg  = w_z_e < w_z_s;
    assign w_adz  = w_neg ? (w_z_s - w_z_e) : (w_z_e - w_z_s);
    assign w_base = ADDR_W'(io_span.y_coord) * ADDR_W'(H_RES) + ADDR_W'(w_x_lo);

    // One restoring-division step: r_quo shifts the dividend out and the quotient in.
    logic [16:0] w_dx17;
    logic [16:0] w_shift;
    logic        w_ge;
    logic [15:0] w_rem_next;

    assign w_dx17     = {1'b0, r_dx};
    assign w_shift    = {r_rem, r_quo[15]};
    assign w_ge       = w_shift >= w_dx17;
    assign w_rem_next = w_ge ? 16'(w_shift - w_dx17) : w_shift[15:0];

    // Depth stepping: z advances by q per pixel plus one whenever the remainder wraps.
    logic [16:0] w_err_sum;
    logic        w_carry;
    logic [15:0] w_err_next;
    logic [15:0] w_zinc;
    logic [15:0] w_x_inc;
    logic        w_last;
    logic        w_cur_clip;
    logic        w_nxt_clip;

    assign w_err_sum  = {1'b0, r_err} + {1'b0, r_rem};
    assign w_carry    = w_err_sum >= w_dx17;
    assign w_err_next = w_carry ? 16'(w_err_sum - w_dx17) : w_err_sum[15:0];
    assign w_zinc     = r_quo + {15'd0, w_carry};
    assign w_x_inc    = r_x + 16'd1;
    assign w_last     = r_x == r_end_x;
    assign w_cur_clip = {1'b0, r_x} >= HRES_L;
    assign w_nxt_clip = {1'b0, w_x_inc} >= HRES_L;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (io_span.draw) begin
                    w_next = DIV;
                end
            end
            DIV: begin
                if (r_cnt == 4'd15) begin
                    w_next = w_cur_clip ? STEP : PIX_ENTRY;
                end
            end
`ifdef SPAN_FILL_ZTEST_EN
            READ: begin
                w_next = TEST;
            end
            TEST: begin
                // Strictly nearer wins; an equal depth leaves the stored pixel alone.
                w_next = (r_z < io_span.zb_rd_data) ? WRITE : STEP;
            end
`endif
            WRITE: begin
                if (io_span.pix_ready) begin
                    w_next = STEP;
                end
            end
            STEP: begin
                if (w_last) begin
                    w_next = DONE;
                end else begin
                    w_next = w_nxt_clip ? STEP : PIX_ENTRY;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_x     <= '0;
            r_end_x <= '0;
            r_z     <= '0;
            r_dx    <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_err   <= '0;
            r_sign  <= 1'b0;
            r_color <= '0;
            r_addr  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (io_span.draw) begin
                        r_x     <= w_x_lo;
                        r_end_x <= w_x_hi;
                        r_z     <= w_z_s;
                        r_dx    <= w_x_hi - w_x_lo;
                        r_quo   <= w_adz;
                        r_rem   <= '0;
                        r_err   <= '0;
                        r_sign  <= w_neg;
                        r_color <= io_span.color;
                        r_addr  <= w_base;
                        r_cnt   <= '0;
                    end
                end
                DIV: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15 && r_dx == 16'd0) begin
                        r_quo <= '0;
                        r_rem <= '0;
                    end else begin
                        r_quo <= {r_quo[14:0], w_ge};
                        r_rem <= w_rem_next;
                    end
                end
                STEP: begin
                    if (!w_last) begin
                        r_x    <= w_x_inc;
                        r_addr <= r_addr + ADDR_W'(1);
                        r_err  <= w_err_next;
                        r_z    <= r_sign ? (r_z - w_zinc) : (r_z + w_zinc);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        io_span.zb_rd_en = 1'b0;
        io_span.pix_we   = 1'b0;
        io_span.done     = 1'b0;
        io_span.busy     = 1'b1;
        case (r_state)
`ifdef SPAN_FILL_ZTEST_EN
            READ:    io_span.zb_rd_en = 1'b1;
`endif
            WRITE:   io_span.pix_we = 1'b1;
            IDLE:    io_span.busy = 1'b0;
            DONE: begin
                io_span.done = 1'b1;
                io_span.busy = 1'b0;
            end
            default: begin
            end
        endcase
    end

`ifndef SPAN_FILL_ZTEST_EN
    logic w_zb_unused;
    assign w_zb_unused = ^io_span.zb_rd_data;
`endif

    assign io_span.zb_rd_addr = r_addr;
    assign io_span.pix_addr   = r_addr;
    assign io_span.pix_z      = r_z;
    assign io_span.pix_color  = r_color;
    assign o_dbg_state        = r_state;
endmodule

// File: tb/tb_span_fill.sv
// Directed bench for span_fill: arithmetic span model, per-cycle write/read checker.
`timescale 1ns/1ps
module tb_span_fill;
    localparam int H_RES  = 640;
    localparam int ADDR_W = 19;
    localparam int W      = ADDR_W + 16 + 8;
`ifdef SPAN_FILL_ZTEST_EN
    localparam bit ZT = 1'b1;
`else
    localparam bit ZT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] dbg_state;
    int         cyc = 0;
    int         t0 = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    span_fill_if #(.ADDR_W(ADDR_W)) bus ();

    span_fill #(.H_RES(H_RES), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .io_span    (bus),
        .o_dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0]      exp_q[$];
    logic [ADDR_W-1:0] rd_q[$];
    logic [W-1:0]      wr_log[$];
    int                first_we = -1;
    bit                we_held = 1'b0;
    logic [W-1:0]      held_v;
    logic [W-1:0]      cmp_got;
    bit                pend_rd = 1'b0;
    logic [ADDR_W-1:0] pend_addr;
    int                zb_mode = 0;
    logic [15:0]       zb_fill = 16'hFFFF;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pack(input int a, input int z, input int c);
        return {ADDR_W'(a), 16'(z), 8'(c)};
    endfunction

    function automatic logic [15:0] zb_val(input logic [ADDR_W-1:0] a);
        if (zb_mode == 1 && a[0]) return 16'd0;
        return zb_fill;
    endfunction

    // Z-buffer memory: answers a read strobe with data during the following cycle.
    always @(posedge clk) begin
        #1;
        bus.zb_rd_data = pend_rd ? zb_val(pend_addr) : 16'($urandom);
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        cmp_got = {bus.pix_addr, bus.pix_z, bus.pix_color};
        if (!rst_n) begin
            we_held = 1'b0;
            pend_rd = 1'b0;
        end else begin
            if (bus.pix_we) begin
                if (first_we < 0) first_we = cyc - t0;
                if (we_held) check("pix_hold_stable", cmp_got, held_v);
                if (bus.pix_ready) begin
                    check("pix_write_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check("pix_write", cmp_got, exp_q.pop_front());
                    wr_log.push_back(cmp_got);
                    we_held = 1'b0;
                end else begin
                    we_held = 1'b1;
                    held_v  = cmp_got;
                end
            end else if (we_held) begin
                check("pix_we_held", bus.pix_we, 1);
                we_held = 1'b0;
            end
            if (bus.zb_rd_en) begin
                check("zb_read_expected", rd_q.size() > 0, 1);
                if (rd_q.size() > 0) check("zb_rd_addr", bus.zb_rd_addr, rd_q.pop_front());
            end
            pend_rd   = bus.zb_rd_en;
            pend_addr = bus.zb_rd_addr;
        end
    end

    // ---------------- model ----------------
    // Depth of pixel k is z_start +/- floor(k*|dz|/dx); cost is cycles spent after DIV.
    task automatic build_model(input int sx, input int ex, input int z1, input int z2,
                               input int y, input int col, output int cost);
        int xl, xh, zs, ze, dx, adz, sgn;
        if (sx > ex) begin
            xl = ex; xh = sx; zs = z2; ze = z1;
        end else begin
            xl = sx; xh = ex; zs = z1; ze = z2;
        end
        dx   = xh - xl;
        adz  = (ze >= zs) ? (ze - zs) : (zs - ze);
        sgn  = (ze >= zs) ? 1 : -1;
        cost = 0;
        for (int k = 0; k <= dx; k++) begin
            int px, pz;
            bit wr;
            logic [ADDR_W-1:0] a;
            px = xl + k;
            pz = zs + sgn * ((dx == 0) ? 0 : int'((longint'(k) * adz) / dx));
            a  = ADDR_W'(y * H_RES + px);
            if (px >= H_RES) begin
                cost += 1;
            end else begin
                wr = !ZT || (pz < int'(zb_val(a)));
                if (ZT) rd_q.push_back(a);
                if (wr) exp_q.push_back(pack(int'(a), pz, col));
                cost += ZT ? (wr ? 4 : 3) : 2;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_span(input int sx, input int ex, input int z1, input int z2,
                              input int y, input int col);
        bus.start_x = 16'(sx);
        bus.end_x   = 16'(ex);
        bus.zout1   = 16'(z1);
        bus.zout2   = 16'(z2);
        bus.y_coord = 16'(y);
        bus.color   = 8'(col);
    endtask

    task automatic check_quiet(input string name);
        check({name, "_ctrl"}, {bus.zb_rd_en, bus.pix_we, bus.done, bus.busy}, 0);
        check({name, "_addr"}, {bus.zb_rd_addr, bus.pix_addr}, 0);
        check({name, "_data"}, {bus.pix_z, bus.pix_color}, 0);
    endtask

    task automatic run_span(input int sx, input int ex, input int z1, input int z2,
                            input int y, input int col, input int stall, input int extra_at);
        int cost, rel, seen;
        bit got_done;
        build_model(sx, ex, z1, z2, y, col, cost);
        wr_log.delete();
        first_we = -1;
        @(posedge clk); #1;
        drive_span(sx, ex, z1, z2, y, col);
        bus.draw      = 1'b1;
        bus.pix_ready = (stall == 0);
        t0 = cyc;
        seen = 0;
        rel = 0;
        got_done = 1'b0;
        for (int i = 0; i < 3000 && !got_done; i++) begin
            @(posedge clk); #1;
            rel = cyc - t0;
            bus.draw = (rel == extra_at);
            if (rel == extra_at) drive_span(0, 3, 1, 2, 1, 8'hEE);
            if (bus.pix_we && !bus.pix_ready) begin
                if (seen == stall) bus.pix_ready = 1'b1;
                else seen++;
            end
            if (bus.done) got_done = 1'b1;
        end
        bus.draw = 1'b0;
        check("done_reached", got_done, 1);
        check("done_cycle", rel, 16 + cost + 1 + stall);
        check("writes_outstanding", exp_q.size(), 0);
        check("reads_outstanding", rd_q.size(), 0);
        check("busy_at_done", bus.busy, 0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int cost;
        bus.draw = 1'b0;
        drive_span(0, 0, 0, 0, 0, 0);
        bus.pix_ready  = 1'b1;
        bus.zb_rd_data = 16'd0;

        // Reset state, and quiet after release until a draw.
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset_hold");
        check("reset_dbg_state", dbg_state, 0);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check_quiet("after_release");
        end

        // Increasing z on scanline 2.
        zb_mode = 0; zb_fill = 16'hFFFF;
        run_span(10, 13, 100, 106, 2, 8'h5A, 0, -1);
        check("inc_first_write_cycle", first_we, ZT ? 19 : 17);
        check("inc_write_count", wr_log.size(), 4);
        check("inc_first_pix", wr_log[0], pack(1290, 100, 8'h5A));
        check("inc_pix1", wr_log[1], pack(1291, 102, 8'h5A));
        check("inc_last_pix", wr_log[3], pack(1293, 106, 8'h5A));
        check("inc_done_level", bus.done, 1);

        // Decreasing z with a remainder; last pixel lands on z_end.
        run_span(0, 3, 10, 0, 0, 8'h11, 0, -1);
        check("dec_z0", wr_log[0][23:8], 10);
        check("dec_z1", wr_log[1][23:8], 7);
        check("dec_z2", wr_log[2][23:8], 4);
        check("dec_z3_end", wr_log[3][23:8], 0);

        // Endpoints given right to left; draw pulse during WRITE is ignored.
        run_span(13, 10, 100, 106, 2, 8'h22, 0, 19);
        check("swap_first_pix", wr_log[0], pack(1290, 106, 8'h22));
        check("swap_last_pix", wr_log[3], pack(1293, 100, 8'h22));

        // Single pixel: equal depth fails the test, nearer depth passes.
        zb_fill = 16'd50;
        run_span(5, 5, 50, 50, 0, 8'h33, 0, -1);
        check("single_eq_writes", wr_log.size(), ZT ? 0 : 1);
        zb_fill = 16'd51;
        run_span(5, 5, 50, 50, 0, 8'h33, 0, -1);
        check("single_lt_writes", wr_log.size(), 1);
        check("single_lt_pix", wr_log[0], pack(5, 50, 8'h33));

        // Right-edge clipping with 5 cycles of write backpressure.
        zb_fill = 16'hFFFF;
        run_span(638, 641, 200, 203, 0, 8'h44, 5, -1);
        check("clip_write_count", wr_log.size(), 2);
        check("clip_addr0", wr_log[0][W-1:24], 638);
        check("clip_addr1", wr_log[1][W-1:24], 639);

        // Alternating z-buffer contents, remainder stepping, draw during DIV ignored.
        zb_mode = 1;
        run_span(100, 110, 1000, 3, 7, 8'h55, 0, 5);
        zb_mode = 0;

        // Long span up to full-scale depth; final depth equals the stored maximum.
        run_span(0, 299, 0, 65535, 1, 8'h66, 0, -1);
        check("long_write_count", wr_log.size(), ZT ? 299 : 300);

        // Reset while a write is pending.
        build_model(10, 13, 100, 106, 2, 8'h77, cost);
        @(posedge clk); #1;
        drive_span(10, 13, 100, 106, 2, 8'h77);
        bus.draw      = 1'b1;
        bus.pix_ready = 1'b0;
        t0 = cyc;
        @(posedge clk); #1;
        bus.draw = 1'b0;
        for (int i = 0; i < 100 && !bus.pix_we; i++) begin
            @(posedge clk); #1;
        end
        check("rst_mid_reached_write", bus.pix_we, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_pix_we", bus.pix_we, 0);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_done", bus.done, 0);
        check_quiet("rst_mid");
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        rd_q.delete();
        repeat (5) begin
            @(posedge clk); #1;
            check_quiet("rst_mid_release");
        end
        bus.pix_ready = 1'b1;

        // Normal operation resumes after the mid-span reset.
        run_span(10, 13, 100, 106, 2, 8'h5A, 0, -1);
        check("recover_write_count", wr_log.size(), 4);
        check("recover_last_pix", wr_log[3], pack(1293, 106, 8'h5A));

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
